nand_bus_responder: RTL and testbench

NAND_BUS_RESPONDER -- requirements
Module: nand_bus_responder

---
 rtl/nand_bus_responder.sv | 156 +++++++++++++++
 tb/tb_nand_bus_responder.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/nand_bus_responder.sv
// NAND DQ bus burst responder: emits a patterned data burst
// with strobe on the selected chip enable, aborting on bus conflict.
module nand_bus_responder #(
  parameter int DQ_W      = 8,
  parameter int NUM_CE    = 2,
  parameter int BURST_LEN = 4
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              start,
  input  logic [1:0]        cfg_mode,
  input  logic [DQ_W-1:0]   cfg_seed,
  input  logic [NUM_CE-1:0] ce_n,
  input  logic              ale,
  input  logic              cle,
  output logic [DQ_W-1:0]   dq_out,
  output logic              dqs_out,
  output logic              dq_oe,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [8:0]        word_cnt
);

  localparam int CI_W = (NUM_CE > 1) ? $clog2(NUM_CE) : 1;
  localparam logic [DQ_W-1:0] TAPS =
    (DQ_W == 16) ? DQ_W'(16'hB400) : DQ_W'(8'hB8);
  localparam logic [8:0] LAST = 9'(BURST_LEN);

  typedef enum logic [1:0] {
    IDLE,
    PRE,
    BURST,
    POST
  } state_t;

  state_t            state;
  logic [1:0]        mode_q;
  logic [NUM_CE-1:0] ce_mask_q;
  logic [DQ_W-1:0]   pat_q;

  logic [CI_W-1:0]   ce_idx;
  logic [2:0]        ce_zeros;
  logic              start_ok;
  logic              abort;
  logic [DQ_W-1:0]   eff_seed;
  logic [DQ_W-1:0]   lfsr_seed;
  logic [7:0]        fixed_b;
  logic [DQ_W-1:0]   cur_word;
  logic [DQ_W-1:0]   next_pat;

  always_comb begin
    ce_idx   = '0;
    ce_zeros = '0;
    for (int i = 0; i < NUM_CE; i++) begin
      if (!ce_n[i]) begin
        ce_zeros = ce_zeros + 3'd1;
        ce_idx   = CI_W'(i);
      end
    end
  end

  assign start_ok = start && !ale && !cle
                 && (ce_zeros == 3'd1)
                 && (cfg_mode != 2'd3);

  // only the chip enable latched at start can abort the burst
  assign abort = ale || cle || (|(ce_mask_q & ce_n));

  assign eff_seed  = cfg_seed ^ DQ_W'(ce_idx);
  assign lfsr_seed = (eff_seed == '0) ? '1 : eff_seed;

  always_comb begin
    fixed_b = 8'hDE;
    case (word_cnt[1:0])
      2'd0:    fixed_b = 8'hDE;
      2'd1:    fixed_b = 8'hAD;
      2'd2:    fixed_b = 8'hBE;
      default: fixed_b = 8'hEF;
    endcase
  end

  assign cur_word = (mode_q == 2'd0) ? {(DQ_W/8){fixed_b}} : pat_q;

  always_comb begin
    next_pat = pat_q + DQ_W'(1);
    if (mode_q == 2'd2)
      next_pat = (pat_q >> 1) ^ (pat_q[0] ? TAPS : '0);
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state     <= IDLE;
      mode_q    <= '0;
      ce_mask_q <= '0;
      pat_q     <= '0;
      dq_out    <= '0;
      dqs_out   <= 1'b0;
      dq_oe     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      word_cnt  <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (start_ok) begin
              state     <= PRE;
              busy      <= 1'b1;
              dq_oe     <= 1'b1;
              dqs_out   <= 1'b0;
              dq_out    <= '0;
              word_cnt  <= '0;
              mode_q    <= cfg_mode;
              ce_mask_q <= ~ce_n;
              pat_q     <= (cfg_mode == 2'd2) ? lfsr_seed : eff_seed;
            end else begin
              err <= 1'b1;
            end
          end
        end
        PRE, BURST: begin
          if (abort) begin
            state   <= IDLE;
            busy    <= 1'b0;
            dq_oe   <= 1'b0;
            dqs_out <= 1'b0;
            dq_out  <= '0;
            err     <= 1'b1;
          end else if (state == BURST && word_cnt == LAST) begin
            state   <= POST;
            dqs_out <= 1'b0;
            done    <= 1'b1;
          end else begin
            state    <= BURST;
            dq_out   <= cur_word;
            dqs_out  <= ~word_cnt[0];
            word_cnt <= word_cnt + 9'd1;
            pat_q    <= next_pat;
          end
        end
        default: begin
          state   <= IDLE;
          busy    <= 1'b0;
          dq_oe   <= 1'b0;
          dqs_out <= 1'b0;
          dq_out  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nand_bus_responder.sv
// Directed bench for nand_bus_responder at default parameters:
// packed per-cycle output vectors against hand-computed values.
module tb_nand_bus_responder;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       start;
  logic [1:0] cfg_mode;
  logic [7:0] cfg_seed;
  logic [1:0] ce_n;
  logic       ale;
  logic       cle;
  logic [7:0] dq_out;
  logic       dqs_out;
  logic       dq_oe;
  logic       busy;
  logic       done;
  logic       err;
  logic [8:0] word_cnt;

  int n_chk = 0;
  int n_err = 0;

  nand_bus_responder dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .start    (start),
    .cfg_mode (cfg_mode),
    .cfg_seed (cfg_seed),
    .ce_n     (ce_n),
    .ale      (ale),
    .cle      (cle),
    .dq_out   (dq_out),
    .dqs_out  (dqs_out),
    .dq_oe    (dq_oe),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .word_cnt (word_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // packed as {busy, oe, dqs, done, err, word_cnt, dq}
  task automatic cyc(input string tag,
                     input bit b, input bit oe, input bit s,
                     input bit d, input bit e,
                     input int wc, input int dq);
    logic [8:0] wcv;
    logic [7:0] dqv;
    wcv = wc[8:0];
    dqv = dq[7:0];
    chk(tag,
        {10'd0, busy, dq_oe, dqs_out, done, err, word_cnt, dq_out},
        {10'd0, b, oe, s, d, e, wcv, dqv});
  endtask

  task automatic go(input logic [1:0] m, input logic [7:0] sd,
                    input logic [1:0] ce);
    cfg_mode = m;
    cfg_seed = sd;
    ce_n     = ce;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  initial begin
    RST_N    = 1'b0;
    start    = 1'b0;
    cfg_mode = 2'd0;
    cfg_seed = 8'h00;
    ce_n     = 2'b11;
    ale      = 1'b0;
    cle      = 1'b0;
    tick();
    tick();
    cyc("reset", 0, 0, 0, 0, 0, 0, 8'h00);
    RST_N = 1'b1;
    tick();
    cyc("idle", 0, 0, 0, 0, 0, 0, 8'h00);

    go(2'd0, 8'h00, 2'b10);
    cyc("m0 pre", 1, 1, 0, 0, 0, 0, 8'h00);
    tick(); cyc("m0 w0", 1, 1, 1, 0, 0, 1, 8'hDE);
    tick(); cyc("m0 w1", 1, 1, 0, 0, 0, 2, 8'hAD);
    tick(); cyc("m0 w2", 1, 1, 1, 0, 0, 3, 8'hBE);
    tick(); cyc("m0 w3", 1, 1, 0, 0, 0, 4, 8'hEF);
    tick(); cyc("m0 post", 1, 1, 0, 1, 0, 4, 8'hEF);
    tick(); cyc("m0 idle", 0, 0, 0, 0, 0, 4, 8'h00);

    go(2'd1, 8'hFE, 2'b01);
    cyc("m1 pre", 1, 1, 0, 0, 0, 0, 8'h00);
    tick(); cyc("m1 w0", 1, 1, 1, 0, 0, 1, 8'hFF);
    start = 1'b1;
    tick(); cyc("m1 w1", 1, 1, 0, 0, 0, 2, 8'h00);
    start = 1'b0;
    tick(); cyc("m1 w2", 1, 1, 1, 0, 0, 3, 8'h01);
    tick(); cyc("m1 w3", 1, 1, 0, 0, 0, 4, 8'h02);
    tick(); cyc("m1 post", 1, 1, 0, 1, 0, 4, 8'h02);
    tick(); cyc("m1 idle", 0, 0, 0, 0, 0, 4, 8'h00);

    // zero seed becomes FF; 7F^B8=C7, 63^B8=DB, 6D^B8=D5
    go(2'd2, 8'h00, 2'b10);
    cyc("m2 pre", 1, 1, 0, 0, 0, 0, 8'h00);
    tick(); cyc("m2 w0", 1, 1, 1, 0, 0, 1, 8'hFF);
    tick(); cyc("m2 w1", 1, 1, 0, 0, 0, 2, 8'hC7);
    tick(); cyc("m2 w2", 1, 1, 1, 0, 0, 3, 8'hDB);
    tick(); cyc("m2 w3", 1, 1, 0, 0, 0, 4, 8'hD5);
    tick(); cyc("m2 post", 1, 1, 0, 1, 0, 4, 8'hD5);
    tick(); cyc("m2 idle", 0, 0, 0, 0, 0, 4, 8'h00);

    go(2'd0, 8'h00, 2'b00);
    cyc("rej ce", 0, 0, 0, 0, 1, 4, 8'h00);
    tick(); cyc("rej ce clr", 0, 0, 0, 0, 0, 4, 8'h00);
    ale = 1'b1;
    go(2'd0, 8'h00, 2'b10);
    ale = 1'b0;
    cyc("rej ale", 0, 0, 0, 0, 1, 4, 8'h00);
    go(2'd3, 8'h00, 2'b10);
    cyc("rej mode3", 0, 0, 0, 0, 1, 4, 8'h00);
    tick(); cyc("rej clr", 0, 0, 0, 0, 0, 4, 8'h00);

    go(2'd0, 8'h00, 2'b01);
    tick(); cyc("ab w0", 1, 1, 1, 0, 0, 1, 8'hDE);
    tick(); cyc("ab w1", 1, 1, 0, 0, 0, 2, 8'hAD);
    tick(); cyc("ab w2", 1, 1, 1, 0, 0, 3, 8'hBE);
    cle = 1'b1;
    tick(); cyc("abort", 0, 0, 0, 0, 1, 3, 8'h00);
    cle = 1'b0;
    tick(); cyc("abort clr", 0, 0, 0, 0, 0, 3, 8'h00);

    go(2'd0, 8'h00, 2'b10);
    tick(); cyc("ce ab w0", 1, 1, 1, 0, 0, 1, 8'hDE);
    ce_n = 2'b11;
    tick(); cyc("ce abort", 0, 0, 0, 0, 1, 1, 8'h00);

    go(2'd1, 8'h10, 2'b10);
    tick(); cyc("rs w0", 1, 1, 1, 0, 0, 1, 8'h10);
    tick(); cyc("rs w1", 1, 1, 0, 0, 0, 2, 8'h11);
    RST_N = 1'b0;
    tick(); cyc("rs hold", 0, 0, 0, 0, 0, 0, 8'h00);
    RST_N = 1'b1;
    tick(); cyc("rs quiet", 0, 0, 0, 0, 0, 0, 8'h00);
    go(2'd1, 8'h20, 2'b01);
    cyc("rs pre", 1, 1, 0, 0, 0, 0, 8'h00);
    tick(); cyc("rs2 w0", 1, 1, 1, 0, 0, 1, 8'h21);
    tick(); cyc("rs2 w1", 1, 1, 0, 0, 0, 2, 8'h22);
    tick(); cyc("rs2 w2", 1, 1, 1, 0, 0, 3, 8'h23);
    tick(); cyc("rs2 w3", 1, 1, 0, 0, 0, 4, 8'h24);
    tick(); cyc("rs2 post", 1, 1, 0, 1, 0, 4, 8'h24);
    tick(); cyc("rs2 idle", 0, 0, 0, 0, 0, 4, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
